// File: rtl/adc_pkg.sv
// Shared constants and helpers for the ADC channel aligner and its FIFOs.
package adc_pkg;

  // Default geometry: four channels of I/Q sample pairs, eight entries deep.
  localparam int NUM_CH_DEF = 4;
  localparam int CH_W_DEF   = 24;
  localparam int DEPTH_DEF  = 8;

  // Each channel word carries two lanes (I and Q) of this width.
  localparam int LANE_W     = 12;

  // Fill counters must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with binary pointers and an explicit fill count.
// A write into a full FIFO is accepted only when a read retires an entry in
// the same cycle; otherwise it is ignored here and reported by the parent.
module sync_fifo
  import adc_pkg::*;
#(
  parameter int WIDTH = CH_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LEVEL_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LEVEL_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] level_r;
  logic             wr_acc_s;
  logic             rd_acc_s;

  assign full_o    = (level_r == LEVEL_FULL);
  assign empty_o   = (level_r == {CNT_W{1'b0}});
  assign rd_acc_s  = rd_en_i & ~empty_o;
  assign wr_acc_s  = wr_en_i & (~full_o | rd_acc_s);
  assign rd_data_o = mem_r[rd_ptr_r];
  assign level_o   = level_r;

  // Storage array: captures accepted writes; not reset since level gates reads.
  always_ff @(posedge clk_i) begin
    if (wr_acc_s && !rst_i && !flush_i) begin
      mem_r[wr_ptr_r] <= wr_data_i;
    end
  end

  // Pointer and fill-count bookkeeping; reset and flush both empty the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/adc_channel_aligner.sv
// Buffers NUM_CH independent ADC sample streams and emits one packed frame
// (one sample per channel) whenever every channel has data, over valid/ready.
// Also tracks sticky per-channel overflow and exposes per-channel fill levels.
module adc_channel_aligner
  import adc_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = CH_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [NUM_CH-1:0]       wr_en_i,
  input  logic [NUM_CH*CH_W-1:0]  wr_data_i,
  output logic [NUM_CH*CH_W-1:0]  data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [NUM_CH-1:0]       ovf_o,
  input  logic                    clr_ovf_i,
  output logic [NUM_CH*CNT_W-1:0] level_o
);

  logic [NUM_CH-1:0]       full_s;
  logic [NUM_CH-1:0]       empty_s;
  logic [NUM_CH*CH_W-1:0]  head_s;
  logic [NUM_CH*CNT_W-1:0] level_s;
  logic                    pop_s;
  logic [NUM_CH-1:0]       ovf_evt_s;

  logic [NUM_CH*CH_W-1:0]  data_r;
  logic                    valid_r;
  logic [NUM_CH-1:0]       ovf_r;

  // One FIFO per channel; all are read together by the shared pop decision.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    sync_fifo #(
      .WIDTH (CH_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (flush_i),
      .wr_en_i   (wr_en_i[k]),
      .wr_data_i (wr_data_i[CH_W*k +: CH_W]),
      .rd_en_i   (pop_s),
      .rd_data_o (head_s[CH_W*k +: CH_W]),
      .full_o    (full_s[k]),
      .empty_o   (empty_s[k]),
      .level_o   (level_s[CNT_W*k +: CNT_W])
    );
  end

  // Pop only when every channel has a sample and the output slot is free
  // or being consumed this cycle; ready_i is the only combinational input.
  always_comb begin
    pop_s = 1'b0;
    if ((&(~empty_s)) && (!valid_r || ready_i)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // A write is lost only when its FIFO is full and no pop frees a slot.
  // Flush discards writes silently, so it never raises an overflow.
  always_comb begin
    ovf_evt_s = {NUM_CH{1'b0}};
    if (!flush_i && !pop_s) begin
      ovf_evt_s = wr_en_i & full_s;
    end else begin
      ovf_evt_s = {NUM_CH{1'b0}};
    end
  end

  // Output stage: load a frame on pop, retire it on ready, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      data_r  <= {(NUM_CH*CH_W){1'b0}};
      valid_r <= 1'b0;
    end else if (pop_s) begin
      data_r  <= head_s;
      valid_r <= 1'b1;
    end else if (ready_i) begin
      data_r  <= data_r;
      valid_r <= 1'b0;
    end else begin
      data_r  <= data_r;
      valid_r <= valid_r;
    end
  end

  // Sticky overflow flags; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_r <= {NUM_CH{1'b0}};
    end else if (clr_ovf_i) begin
      ovf_r <= ovf_evt_s;
    end else begin
      ovf_r <= ovf_r | ovf_evt_s;
    end
  end

  assign data_o  = data_r;
  assign valid_o = valid_r;
  assign ovf_o   = ovf_r;
  assign level_o = level_s;

endmodule

// File: doc/adc_channel_aligner.md
Name: adc_channel_aligner

Overview:
- Single-clock, parametrised successor to the two-channel ADC merge stage.
- Takes NUM_CH already clock-domain-crossed ADC sample streams in the clk_i domain, each with its own write strobe, and buffers each stream in a per-channel FIFO.
- Emits one packed word containing one sample from every channel only when all channels hold data, over a valid/ready handshake to the downstream DSP chain.
- Adds overflow detection, sticky error flags, a fill-level readout and a synchronous flush.

Parameters:
- NUM_CH, 4, number of ADC channels (≥1).
- CH_W, 24, bits per channel sample word (two 12-bit lanes for I/Q).
- DEPTH, 8, entries per channel FIFO; must be a power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of the per-channel fill count (derived; do not override).

Ports:
- clk_i, in, 1, system clock.
- rst_i, in, 1, synchronous reset, active-high.
- flush_i, in, 1, synchronous flush of all FIFOs and the output stage.
- wr_en_i, in, NUM_CH, per-channel write strobe; bit k belongs to channel k.
- wr_data_i, in, NUM_CH*CH_W, channel k occupies bits [CH_W*k +: CH_W].
- data_o, out, NUM_CH*CH_W, packed output; channel 0 is in the LSBs, channel NUM_CH-1 in the MSBs.
- valid_o, out, 1, data_o holds an aligned frame.
- ready_i, in, 1, downstream accepts the frame.
- ovf_o, out, NUM_CH, sticky per-channel overflow flags.
- clr_ovf_i, in, 1, clears ovf_o.
- level_o, out, NUM_CH*CNT_W, per-channel fill count; channel k at [CNT_W*k +: CNT_W].

Behaviour:
- Reset (rst_i=1 at a clk_i edge): every FIFO is emptied and every level reads 0. valid_o=0, data_o=0, ovf_o=0. rst_i has priority over every other input.
- Flush (flush_i=1, rst_i=0): same effect as reset on the FIFOs, valid_o and data_o. ovf_o is left unchanged. Writes in the flush cycle are discarded.
- Per-channel write: a write to channel k is accepted when wr_en_i[k]=1 and the FIFO is not full, or is full but popped in the same cycle.
- Write to a full FIFO with no pop in that cycle: the sample is dropped, the FIFO is unchanged, ovf_o[k] is set at that edge.
- Pop condition, evaluated combinationally: all FIFOs non-empty AND (valid_o=0 OR ready_i=1).
- On a pop: one entry is removed from every FIFO simultaneously, the output register loads the concatenated heads, and valid_o=1 at the next edge.
- valid_o=1 and ready_i=1 with no pop: valid_o falls to 0 at the next edge. data_o holds its last value.
- valid_o=1 and ready_i=0: data_o and valid_o are held stable (AXI-style). No pop occurs.
- Latency: a sample written at edge E is counted in level from E. If all other channels are non-empty and the output is free, it appears on data_o with valid_o=1 after edge E+1. Minimum latency is 2 cycles from wr_en_i high to valid_o.
- Throughput: one frame per cycle while all channels keep writing and ready_i stays high.
- Level: incremented on an accepted write and decremented on a pop. Both in one cycle leave it unchanged. Range is 0..DEPTH.
- Pointers: binary, DEPTH-modulo wrap-around. Full when level=DEPTH, empty when level=0.
- ovf_o: clr_ovf_i clears all bits. If an overflow occurs in the same cycle as clr_ovf_i, that bit is set (set wins).
- No combinational path from wr_en_i or wr_data_i to any output. The only combinational path is ready_i into the pop decision.

Decomposition:
- Shared package adc_pkg:
  - default NUM_CH, CH_W, DEPTH constants;
  - localparam CNT_W derivation function;
  - lane width 12.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - ports clk_i, rst_i, flush_i, wr_en_i, wr_data_i, rd_en_i, rd_data_o (show-ahead), full_o, empty_o, level_o;
  - instantiated NUM_CH times in a generate loop.
- The top level holds the pop logic, output register and overflow flags.

Test Plan:
- Reset/flush values: assert rst_i for 2 cycles mid-traffic -> valid_o=0, data_o=0, ovf_o=0, all levels=0 on the next cycle. Repeat with flush_i after ovf_o[1]=1 -> levels=0, valid_o=0, ovf_o[1] still 1.
- Aligned streaming: all four channels write 0x000001..0x000010 every cycle with ready_i=1 -> 16 frames, each with all channel fields equal. First valid_o is 2 cycles after the first write, with no gaps.
- Skewed arrival: channels 0-2 write 3 samples, channel 3 writes nothing -> valid_o stays 0 and levels read 3,3,3,0. Channel 3 then writes 0xA5A5A5 -> one frame with ch3=0xA5A5A5 and ch0-2 holding their first samples.
- Backpressure: ready_i=0 for 5 cycles while valid_o=1 -> data_o stable throughout. Channels fill to level 8. A 9th write to ch2 sets ovf_o[2]=1 and keeps level 8. Raising ready_i drains all samples in order with none lost.
- Full plus simultaneous pop: all FIFOs at 8 with ready_i=1 and writes on all channels -> the write is accepted, level stays 8, ovf_o stays 0.
- Overflow clear race: overflow on ch0 in the same cycle as clr_ovf_i -> ovf_o[0]=1. A clr_ovf_i on the following cycle -> ovf_o=0.
